// File: rtl/seg7_capture.sv
// seg7_capture: takes a snapshot of three active-low 7-segment displays on request.
// It waits until the pattern has held steady, then decodes it into three hex nibbles.
// If the displays never settle within the wait window, it reports a timeout instead.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,    // consecutive matching samples before decode (1..15)
    parameter int MAX_WAIT      = 255   // SETTLE cycles before giving up (STABLE_CYCLES+1..1023)
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [6:0]  HEX0,
    input  logic [6:0]  HEX1,
    input  logic [6:0]  HEX2,
    input  logic        START,
    output logic        BUSY,
    output logic        VALID,
    output logic [11:0] VALUE,
    output logic [2:0]  DIGIT_ERR,
    output logic        TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECODE,
        ST_DONE
    } state_t;

    // Terminal counts are compared against the pre-increment counter value, so a
    // hit means "the counter reaches its limit on this edge".
    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [9:0] WAIT_LAST   = 10'(MAX_WAIT - 1);

    state_t      state;
    state_t      next_state;

    logic [20:0] hex_now;
    logic [20:0] snapshot;
    logic [3:0]  stab_cnt;
    logic [9:0]  wait_cnt;

    logic        sample_match;
    logic        stable_hit;
    logic        wait_hit;

    logic [4:0]  dec0;
    logic [4:0]  dec1;
    logic [4:0]  dec2;
    logic [11:0] decoded_value;
    logic [2:0]  decoded_err;

    // Active-low segment code (g..a) to {illegal, nibble}.
    // An illegal pattern decodes to nibble 0 with the error bit set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'h10;
        case (seg)
            7'b1000000: res = {1'b0, 4'h0};
            7'b1111001: res = {1'b0, 4'h1};
            7'b0100100: res = {1'b0, 4'h2};
            7'b0110000: res = {1'b0, 4'h3};
            7'b0011001: res = {1'b0, 4'h4};
            7'b0010010: res = {1'b0, 4'h5};
            7'b0000010: res = {1'b0, 4'h6};
            7'b1111000: res = {1'b0, 4'h7};
            7'b0000000: res = {1'b0, 4'h8};
            7'b0010000: res = {1'b0, 4'h9};
            7'b0001000: res = {1'b0, 4'hA};
            7'b0000011: res = {1'b0, 4'hB};
            7'b1000110: res = {1'b0, 4'hC};
            7'b0100001: res = {1'b0, 4'hD};
            7'b0000110: res = {1'b0, 4'hE};
            7'b0001110: res = {1'b0, 4'hF};
            default:    res = 5'h10;
        endcase
        return res;
    endfunction

    assign hex_now      = {HEX2, HEX1, HEX0};
    assign sample_match = (hex_now == snapshot);
    assign stable_hit   = sample_match && (stab_cnt == STABLE_LAST);
    assign wait_hit     = (wait_cnt == WAIT_LAST);

    assign dec0          = seg_decode(snapshot[6:0]);
    assign dec1          = seg_decode(snapshot[13:7]);
    assign dec2          = seg_decode(snapshot[20:14]);
    assign decoded_value = {dec2[3:0], dec1[3:0], dec0[3:0]};
    assign decoded_err   = {dec2[4], dec1[4], dec0[4]};

    // State register; reset wins over every transition.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        next_state = state;
        BUSY       = 1'b1;
        VALID      = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // The stable path wins when both limits land on the same edge.
                if (stable_hit) begin
                    next_state = ST_DECODE;
                end else if (wait_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DECODE: begin
                next_state = ST_DONE;
            end
            ST_DONE: begin
                VALID      = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Snapshot and counters: latch on START, then track input changes while settling.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: the snapshot is a plain register and is cleared on reset like the counters.
        if (RESET) begin
            snapshot <= '0;
            stab_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        snapshot <= hex_now;
                        stab_cnt <= '0;
                        wait_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    wait_cnt <= wait_cnt + 10'd1;
                    if (sample_match) begin
                        stab_cnt <= stab_cnt + 4'd1;
                    end else begin
                        // Any change restarts the stability run from the new pattern.
                        snapshot <= hex_now;
                        stab_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: written once per capture, held between VALID pulses.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            VALUE     <= '0;
            DIGIT_ERR <= '0;
            TIMEOUT   <= 1'b0;
        end else if (state == ST_DECODE) begin
            VALUE     <= decoded_value;
            DIGIT_ERR <= decoded_err;
            TIMEOUT   <= 1'b0;
        end else if (state == ST_SETTLE && !stable_hit && wait_hit) begin
            // Timeout leaves VALUE from the previous good capture untouched.
            DIGIT_ERR <= 3'b111;
            TIMEOUT   <= 1'b1;
        end
    end

endmodule
